// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, arbiter state encoding
// and the default byte width.
package uart_pkg;

  localparam int INPUT_DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    UART_IDLE    = 3'd0,
    UART_START   = 3'd1,
    UART_DATA    = 3'd2,
    UART_STOP    = 3'd3,
    UART_CLEANUP = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LAUNCH    = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: the first requester at or after ptr_i
// (wrapping modulo N) wins.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand_idx [N];
  logic [N-1:0]  cand_req;

  // Candidate gi is the requester gi positions after the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum          = {1'b0, ptr_i} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      assign cand_req[gi] = req_i[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx[k];
      end
    end
    grant_o = valid_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQUESTERS clients.
// Optional launch watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQUESTERS   = 4,
  parameter int INPUT_DATA_WIDTH = INPUT_DATA_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQUESTERS-1:0]              req,
  input  logic [NUM_REQUESTERS*INPUT_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]              ack,
  output logic                                   uart_enable,
  output logic [INPUT_DATA_WIDTH-1:0]            uart_data,
  input  logic                                   uart_busy,
  output logic [$clog2(NUM_REQUESTERS)-1:0]      owner,
  output logic                                   active
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                                   timeout_err
`endif
);

  localparam int IW = $clog2(NUM_REQUESTERS);

  arb_state_e                  state_q;
  logic [NUM_REQUESTERS-1:0]   ack_q;
  logic                        uart_enable_q;
  logic [INPUT_DATA_WIDTH-1:0] uart_data_q;
  logic [IW-1:0]               owner_q;
  logic                        active_q;
  logic [IW-1:0]               ptr_q;
  logic [IW-1:0]               ptr_d;

  logic [NUM_REQUESTERS-1:0]   pick_grant;
  logic [IW-1:0]               pick_idx;
  logic                        pick_valid;
  logic [INPUT_DATA_WIDTH-1:0] data_d;

  rr_priority_pick #(
    .N (NUM_REQUESTERS)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign data_d = req_data[pick_idx*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
  assign ptr_d  = (pick_idx == IW'(NUM_REQUESTERS - 1)) ? '0 : pick_idx + IW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;
  logic          timeout_err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      ack_q         <= '0;
      uart_enable_q <= 1'b0;
      uart_data_q   <= '0;
      owner_q       <= '0;
      active_q      <= 1'b0;
      ptr_q         <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      ack_q         <= '0;
      uart_enable_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid && !uart_busy) begin
            ack_q       <= pick_grant;
            uart_data_q <= data_d;
            owner_q     <= pick_idx;
            ptr_q       <= ptr_d;
            active_q    <= 1'b1;
            state_q     <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          // Hold off the strobe if something else grabbed the UART meanwhile.
          if (!uart_busy) begin
            uart_enable_q <= 1'b1;
            state_q       <= ARB_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
          end
        end
        ARB_WAIT_BUSY: begin
          if (uart_busy) begin
            state_q <= ARB_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_q <= 1'b1;
            active_q      <= 1'b0;
            state_q       <= ARB_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
`endif
          end
        end
        ARB_WAIT_DONE: begin
          if (!uart_busy) begin
            active_q <= 1'b0;
            state_q  <= ARB_IDLE;
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= ARB_IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign uart_enable = uart_enable_q;
  assign uart_data   = uart_data_q;
  assign owner       = owner_q;
  assign active      = active_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple looped-back UART model.
// Covers the timeout path too when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           uart_enable;
  logic [W-1:0]   uart_data;
  logic           uart_busy;
  logic [1:0]     owner;
  logic           active;
`ifdef UART_ARB_TIMEOUT_EN
  logic           timeout_err;
`endif

  logic           force_busy = 1'b0;
  logic           model_busy = 1'b0;
  logic           uart_auto  = 1'b1;
  int             checks = 0;
  int             failures = 0;
  int             rx_count = 0;
  int             busy_cnt = 0;
  int             viol = 0;
  logic [W-1:0]   last_rx = '0;
  int             seq [N];

  assign uart_busy = force_busy | model_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQUESTERS   (N),
    .INPUT_DATA_WIDTH (W),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .uart_enable (uart_enable),
    .uart_data   (uart_data),
    .uart_busy   (uart_busy),
    .owner       (owner),
    .active      (active)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic wait_ack(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!active && !uart_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  // UART stand-in: any launch makes it busy for three cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (uart_enable) begin
        if (uart_busy) viol++;
        rx_count++;
        last_rx = uart_data;
        if (uart_auto) begin
          model_busy = 1'b1;
          busy_cnt   = 3;
        end
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) model_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit           ok;
    bit           saw;
    int           e;
    int           n;
    logic [W-1:0] exp_b;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_enable", 32'(uart_enable), 32'h0);
    check_eq("rst_data", 32'(uart_data), 32'h0);
    check_eq("rst_owner", 32'(owner), 32'h0);
    check_eq("rst_active", 32'(active), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single client 1, byte A5
    req = 4'b0010;
    req_data[1*W +: W] = 8'hA5;
    @(negedge clk);
    check_eq("single_ack", 32'(ack), 32'h2);
    check_eq("single_owner", 32'(owner), 32'h1);
    check_eq("single_data", 32'(uart_data), 32'hA5);
    check_eq("single_en_early", 32'(uart_enable), 32'h0);
    req = '0;
    @(negedge clk);
    check_eq("single_enable", 32'(uart_enable), 32'h1);
    check_eq("single_ack_pulse", 32'(ack), 32'h0);
    @(negedge clk);
    check_eq("single_en_pulse", 32'(uart_enable), 32'h0);
    wait_idle("single_idle");
    check_eq("single_rx", 32'(last_rx), 32'hA5);

    // All four requesting; pointer starts after client 1
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      req_data[i*W +: W] = {4'(i + 1), 4'h0};
    end
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_ack(20, ok);
      check_eq($sformatf("rr_wait_%0d", k), 32'(ok), 32'd1);
      e = (2 + k) % N;
      exp_b = {4'(e + 1), 4'(seq[e])};
      check_eq($sformatf("rr_ack_%0d", k), 32'(ack), 32'(1 << e));
      check_eq($sformatf("rr_owner_%0d", k), 32'(owner), 32'(e));
      check_eq($sformatf("rr_data_%0d", k), 32'(uart_data), 32'(exp_b));
      seq[e]++;
      req_data[e*W +: W] = {4'(e + 1), 4'(seq[e])};
    end
    req = '0;
    wait_idle("rr_idle");
    check_eq("rr_rx_count", 32'(rx_count), 32'd9);
    check_eq("rr_last_rx", 32'(last_rx), 32'h21);

    // External busy blocks grants
    force_busy = 1'b1;
    req = 4'b0001;
    req_data[0 +: W] = 8'h77;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack != '0 || uart_enable) saw = 1'b1;
    end
    check_eq("busy_no_grant", 32'(saw), 32'h0);
    check_eq("busy_idle", 32'(active), 32'h0);
    force_busy = 1'b0;
    @(negedge clk);
    check_eq("busy_release_ack", 32'(ack), 32'h1);
    check_eq("busy_release_data", 32'(uart_data), 32'h77);
    req = '0;
    wait_idle("busy_idle_end");

    // Reset in WAIT_DONE
    req = 4'b0100;
    req_data[2*W +: W] = 8'hC3;
    wait_ack(20, ok);
    check_eq("mid_ack", 32'(ack), 32'h4);
    req = '0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("mid_busy_seen", 32'(ok), 32'd1);
    @(negedge clk);
    check_eq("mid_active", 32'(active), 32'h1);
    check_eq("mid_owner", 32'(owner), 32'h2);
    rst_n = 1'b0;
    req = 4'b1001;
    req_data[0 +: W]   = 8'h5A;
    req_data[3*W +: W] = 8'h3C;
    #1;
    check_eq("async_ack", 32'(ack), 32'h0);
    check_eq("async_enable", 32'(uart_enable), 32'h0);
    check_eq("async_data", 32'(uart_data), 32'h0);
    check_eq("async_owner", 32'(owner), 32'h0);
    check_eq("async_active", 32'(active), 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!uart_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("mid_uart_drained", 32'(ok), 32'd1);
    check_eq("mid_no_grant_in_rst", 32'(ack), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ack0", 32'(ack), 32'h1);
    check_eq("post_rst_data0", 32'(uart_data), 32'h5A);
    req = 4'b1000;
    wait_ack(20, ok);
    check_eq("post_rst_ack3", 32'(ack), 32'h8);
    check_eq("post_rst_data3", 32'(uart_data), 32'h3C);
    check_eq("post_rst_owner3", 32'(owner), 32'h3);
    req = '0;
    wait_idle("post_rst_idle");
    check_eq("launch_count", 32'(rx_count), 32'd13);
    check_eq("enable_while_busy", 32'(viol), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
    // UART never answers: watchdog fires and the pointer has moved on
    uart_auto = 1'b0;
    req = 4'b0010;
    req_data[1*W +: W] = 8'h99;
    wait_ack(20, ok);
    check_eq("to_ack", 32'(ack), 32'h2);
    req = '0;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("to_seen", 32'(ok), 32'd1);
    check_eq("to_latency", 32'(n), 32'(TO + 1));
    check_eq("to_idle", 32'(active), 32'h0);
    @(negedge clk);
    check_eq("to_pulse", 32'(timeout_err), 32'h0);
    uart_auto = 1'b1;
    req = 4'b0101;
    wait_ack(20, ok);
    check_eq("to_next_ack", 32'(ack), 32'h4);
    req = '0;
    wait_idle("to_end_idle");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 4, number of clients sharing one UART transmitter (2..8).
REQ-002 Parameter INPUT_DATA_WIDTH, default 8, byte width, matches UART i_data.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, max cycles from launch to uart_busy rising; used only under REQ-029.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-006 Port req  input  NUM_REQUESTERS  per-client request; bit i high = client i has a byte pending.
REQ-007 Port req_data  input  NUM_REQUESTERS*INPUT_DATA_WIDTH  client i byte in slice [i*W +: W].
REQ-008 Port ack  output  NUM_REQUESTERS  one-cycle pulse, bit i = client i byte accepted.
REQ-009 Port uart_enable  output  1  launch strobe to UART enable.
REQ-010 Port uart_data  output  INPUT_DATA_WIDTH  byte to UART i_data.
REQ-011 Port uart_busy  input  1  UART o_busy.
REQ-012 Port owner  output  clog2(NUM_REQUESTERS)  index of client currently holding the UART.
REQ-013 Port active  output  1  high while any state other than IDLE.

Function
REQ-014 States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-015 IDLE with req != 0 and uart_busy == 0: select winner per REQ-020, latch req_data slice into uart_data, set owner, pulse ack[winner] for one cycle, go to LAUNCH.
REQ-016 IDLE with uart_busy == 1 (UART busy from outside the arbiter): no grant, remain IDLE.
REQ-017 LAUNCH: uart_enable = 1 for exactly one cycle, uart_data held; next state WAIT_BUSY.
REQ-018 WAIT_BUSY: stay until uart_busy == 1, then WAIT_DONE; uart_enable = 0.
REQ-019 WAIT_DONE: stay until uart_busy == 0, then IDLE; at least one IDLE cycle between bytes.
REQ-020 Round-robin arbitration: search starts at last granted index + 1 modulo NUM_REQUESTERS; lowest index wins at that offset; after reset, search starts at index 0.
REQ-021 Request-to-uart_enable latency: 2 cycles (grant cycle + LAUNCH).
REQ-022 Client holds req and req_data stable until its ack; after ack it may deassert or present the next byte immediately.
REQ-023 Client deasserting req before ack: no grant for that client, no error.
REQ-024 uart_data and owner unchanged from grant until the next grant.
REQ-025 Never more than one ack bit high; never uart_enable while uart_busy == 1.

Reset
REQ-026 While reset is low: state IDLE, ack = 0, uart_enable = 0, uart_data = 0, owner = 0, active = 0, round-robin pointer so index 0 has priority; takes effect without a clock edge.
REQ-027 Reset asserted mid-transfer: arbiter returns to IDLE at once; byte already handed to UART is not re-sent and not re-acked.
REQ-028 After reset release, first grant no earlier than the first rising edge on which reset is high.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN defined: counter in WAIT_BUSY; if uart_busy not seen within TIMEOUT_CYCLES, go to IDLE and pulse output timeout_err (1 bit, reset 0) for one cycle; the pointer still advances.
REQ-030 UART_ARB_TIMEOUT_EN undefined: no counter, no timeout_err port; WAIT_BUSY waits indefinitely.

Structure
REQ-031 Shared package uart_pkg holds the state encoding constants and INPUT_DATA_WIDTH default, alongside the existing UART state constants.
REQ-032 One sub-module rr_priority_pick: combinational round-robin selector (req vector, pointer -> one-hot winner, index, valid); the FSM stays in uart_tx_arbiter.

Verification
REQ-033 Single client: req = 4'b0010, req_data[1] = 8'hA5 -> ack = 4'b0010 next cycle, uart_enable one cycle later with uart_data = 8'hA5, owner = 1.
REQ-034 All four request continuously with UART looped back -> ack order 0,1,2,3,0,...; no client starved; each byte received equals its req_data.
REQ-035 uart_busy forced high in IDLE with req = 4'b0001 -> no ack, no uart_enable until uart_busy falls.
REQ-036 Reset pulled low in WAIT_DONE -> outputs at reset values asynchronously; after release, req = 4'b1000 and req = 4'b0001 both pending -> client 0 granted first.
REQ-037 With UART_ARB_TIMEOUT_EN, uart_busy tied 0 -> timeout_err pulse TIMEOUT_CYCLES cycles after LAUNCH, return to IDLE, next client granted.
